// File: rtl/tx_frame_control.sv
// tx_frame_control: egress GMII transmit controller for one switch output port.
//   Pops committed frames from a FWFT output queue and transmits them as
//   preamble, SFD, payload, optional zero pad, FCS, then an enforced inter-frame gap.
//   Underruns abort the frame with one tx_er cycle and drain the rest silently.
// Configuration macro: TX_PAD_EN -- when defined, short frames are zero-padded to
//   MIN_FRAME bytes before the FCS; when undefined, the PAD state and MIN_FRAME are absent.
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_fifo_empty   queue empty; i_fifo_data / i_fifo_last valid when 0
//   i_fifo_data    head byte of the queue (DA first, no preamble, no FCS)
//   i_fifo_last    head byte is the last byte of its frame
//   o_fifo_rd_en   pop the head byte this cycle (never while empty)
//   o_gmii_tx_d    registered transmit byte
//   o_gmii_tx_en   registered transmit enable
//   o_gmii_tx_er   registered transmit error (underrun abort)
//   o_tx_busy      high whenever the controller is not idle
//   o_tx_done      pulse on the cycle the last FCS byte is on the line
//   o_tx_underrun  pulse on the cycle the abort error is on the line
module tx_frame_control #(
    parameter int PREAMBLE_LEN = 7,
`ifdef TX_PAD_EN
    parameter int MIN_FRAME    = 60,
`endif
    parameter int IFG_CYCLES   = 12
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    input  logic       i_fifo_last,
    output logic       o_fifo_rd_en,
    output logic [7:0] o_gmii_tx_d,
    output logic       o_gmii_tx_en,
    output logic       o_gmii_tx_er,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_underrun
);
    // Each state names what is being loaded into the output registers this cycle,
    // so the line shows that state's byte one cycle later.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_SFD   = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FCS   = 3'd5;
    localparam logic [2:0] S_IFG   = 3'd6;
`ifdef TX_PAD_EN
    localparam logic [2:0] S_PAD   = 3'd7;
`endif

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_tx_d;
    logic        r_tx_en;
    logic        r_tx_er;
    logic        r_done;
    logic        r_underrun;
    logic [7:0]  w_crc_byte;
    logic [31:0] w_crc_nxt;
    logic [31:0] w_fcs;
    logic [7:0]  w_fcs_byte;
`ifdef TX_PAD_EN
    logic [10:0] r_byte_cnt;
    logic [10:0] w_byte_inc;
`endif

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

`ifdef TX_PAD_EN
    assign w_crc_byte = (r_state == S_PAD) ? 8'h00 : i_fifo_data;
    // Saturate rather than wrap so overlength frames never look short.
    assign w_byte_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
`else
    assign w_crc_byte = i_fifo_data;
`endif
    assign w_crc_nxt  = crc_next(r_crc, w_crc_byte);
    assign w_fcs      = ~r_crc;
    // FCS goes out least-significant byte first.
    assign w_fcs_byte = 8'(w_fcs >> {r_cnt[1:0], 3'b000});

    assign o_fifo_rd_en  = ((r_state == S_DATA) || (r_state == S_DRAIN)) && !i_fifo_empty;
    assign o_tx_busy     = r_state != S_IDLE;
    assign o_gmii_tx_d   = r_tx_d;
    assign o_gmii_tx_en  = r_tx_en;
    assign o_gmii_tx_er  = r_tx_er;
    assign o_tx_done     = r_done;
    assign o_tx_underrun = r_underrun;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_crc      <= '1;
            r_tx_d     <= '0;
            r_tx_en    <= 1'b0;
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef TX_PAD_EN
            r_byte_cnt <= '0;
`endif
        end else begin
            r_tx_er    <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: if (!i_fifo_empty) begin
                    r_tx_en <= 1'b1;
                    r_tx_d  <= 8'h55;
                    r_cnt   <= 16'd1;
                    r_state <= S_PRE;
                end
                S_PRE: begin
                    r_tx_d <= 8'h55;
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt == 16'(PREAMBLE_LEN - 1))
                        r_state <= S_SFD;
                end
                S_SFD: begin
                    r_tx_d  <= 8'hD5;
                    r_crc   <= '1;
`ifdef TX_PAD_EN
                    r_byte_cnt <= '0;
`endif
                    r_state <= S_DATA;
                end
                S_DATA: if (i_fifo_empty) begin
                    // tx_en stays high for this single error cycle.
                    r_tx_d     <= 8'h00;
                    r_tx_er    <= 1'b1;
                    r_underrun <= 1'b1;
                    r_state    <= S_DRAIN;
                end else begin
                    r_tx_d <= i_fifo_data;
                    r_crc  <= w_crc_nxt;
`ifdef TX_PAD_EN
                    r_byte_cnt <= w_byte_inc;
`endif
                    if (i_fifo_last) begin
                        r_cnt <= '0;
`ifdef TX_PAD_EN
                        r_state <= (w_byte_inc < 11'(MIN_FRAME)) ? S_PAD : S_FCS;
`else
                        r_state <= S_FCS;
`endif
                    end
                end
`ifdef TX_PAD_EN
                S_PAD: begin
                    r_tx_d     <= 8'h00;
                    r_crc      <= w_crc_nxt;
                    r_byte_cnt <= w_byte_inc;
                    if (w_byte_inc >= 11'(MIN_FRAME))
                        r_state <= S_FCS;
                end
`endif
                S_DRAIN: begin
                    r_tx_en <= 1'b0;
                    r_tx_d  <= 8'h00;
                    if (!i_fifo_empty && i_fifo_last) begin
                        r_cnt   <= '0;
                        r_state <= S_IFG;
                    end
                end
                S_FCS: begin
                    r_tx_d <= w_fcs_byte;
                    r_cnt  <= r_cnt + 16'd1;
                    if (r_cnt[1:0] == 2'd3) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IFG;
                    end
                end
                S_IFG: begin
                    r_tx_en <= 1'b0;
                    r_tx_d  <= 8'h00;
                    r_cnt   <= r_cnt + 16'd1;
                    if (r_cnt == 16'(IFG_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_frame_control.sv
// tb_tx_frame_control: directed table-driven bench for tx_frame_control with a FWFT queue model.
module tb_tx_frame_control;
    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data  = 8'h00;
    logic       fifo_last  = 1'b0;
    logic       rd_en;
    logic [7:0] tx_d;
    logic       tx_en, tx_er, busy, done, underrun;

    tx_frame_control dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data),
        .i_fifo_last(fifo_last), .o_fifo_rd_en(rd_en), .o_gmii_tx_d(tx_d), .o_gmii_tx_en(tx_en),
        .o_gmii_tx_er(tx_er), .o_tx_busy(busy), .o_tx_done(done), .o_tx_underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] seed;
        int         exp_en;
    } vec_t;

`ifdef TX_PAD_EN
    localparam int EXP10 = 72;
    localparam int EXP1  = 72;
`else
    localparam int EXP10 = 22;
    localparam int EXP1  = 13;
`endif

    vec_t       vecs[5];
    logic [8:0] q[$];
    logic       force_empty = 1'b0;
    int         checks = 0, errors = 0;
    int         n = 0, pops = 0, mark_pops = -1, mark_step = -1, viol = 0;
    logic [7:0] lg_d[1024];
    logic       lg_en[1024], lg_er[1024], lg_done[1024], lg_ur[1024];
    int         rs[8], rl[8], nr, nd, ne, nu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_frame(input int len, input logic [7:0] seed);
        for (int i = 0; i < len; i++) q.push_back({i == len - 1, 8'(seed + i)});
    endtask

    task automatic step();
        logic pop;
        @(negedge clk);
        if (q.size() == 0 || force_empty) begin
            fifo_empty = 1'b1;
            fifo_data  = 8'h00;
            fifo_last  = 1'b0;
        end else begin
            fifo_empty = 1'b0;
            fifo_data  = q[0][7:0];
            fifo_last  = q[0][8];
        end
        #1;
        pop = rd_en;
        if (pop && fifo_empty) viol++;
        @(posedge clk);
        if (pop && !fifo_empty) begin
            void'(q.pop_front());
            pops++;
            if (pops == mark_pops) mark_step = n;
        end
        #1;
        if (n < 1024) begin
            lg_d[n]    = tx_d;
            lg_en[n]   = tx_en;
            lg_er[n]   = tx_er;
            lg_done[n] = done;
            lg_ur[n]   = underrun;
            n++;
        end
    endtask

    task automatic analyze();
        nr = 0; nd = 0; ne = 0; nu = 0;
        for (int i = 0; i < n; i++) begin
            nd += int'(lg_done[i]);
            ne += int'(lg_er[i]);
            nu += int'(lg_ur[i]);
            if (lg_en[i]) begin
                if (i == 0 || !lg_en[i-1]) begin
                    if (nr < 8) begin
                        rs[nr] = i;
                        rl[nr] = 0;
                    end
                    nr++;
                end
                if (nr <= 8) rl[nr-1]++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int st, input int ln, input int len, input logic [7:0] seed);
        int          bad_pre, bad_dat, pl;
        logic [7:0]  e;
        logic [31:0] c, rc, fcs;
        bad_pre = 0; bad_dat = 0; pl = ln - 12;
        c = '1; rc = '1;
        if (pl < 0) pl = 0;
        for (int i = 0; i < 7; i++) if (lg_d[st+i] !== 8'h55) bad_pre++;
        if (lg_d[st+7] !== 8'hD5) bad_pre++;
        for (int i = 0; i < pl; i++) begin
            e = (i < len) ? 8'(seed + i) : 8'h00;
            if (lg_d[st+8+i] !== e) bad_dat++;
            c = crc_upd(c, e);
        end
        fcs = {lg_d[st+ln-1], lg_d[st+ln-2], lg_d[st+ln-3], lg_d[st+ln-4]};
        for (int i = 8; i < ln; i++) rc = crc_upd(rc, lg_d[st+i]);
        check({tag, "_preamble_bad"}, bad_pre, 0);
        check({tag, "_payload_bad"}, bad_dat, 0);
        check({tag, "_fcs"}, fcs, ~c);
        check({tag, "_residue"}, rc, 32'hDEBB20E3);
        check({tag, "_done_last"}, 32'(lg_done[st+ln-1]), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        vecs[0] = '{60, 8'h00, 72};
        vecs[1] = '{10, 8'hA0, EXP10};
        vecs[2] = '{1,  8'h5A, EXP1};
        vecs[3] = '{64, 8'h10, 76};
        vecs[4] = '{61, 8'h33, 73};

        repeat (3) step();
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_tx_er", 32'(tx_er), 0);
        check("rst_tx_d", 32'(tx_d), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step();
        check("idle_tx_en", 32'(tx_en), 0);
        check("idle_busy", 32'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            n = 0;
            push_frame(vecs[v].len, vecs[v].seed);
            repeat (vecs[v].exp_en + 20) step();
            analyze();
            check($sformatf("v%0d_runs", v), nr, 1);
            if (nr >= 1) begin
                check($sformatf("v%0d_start", v), rs[0], 0);
                check($sformatf("v%0d_tx_en_cycles", v), rl[0], vecs[v].exp_en);
                check_frame($sformatf("v%0d", v), rs[0], rl[0], vecs[v].len, vecs[v].seed);
            end
            check($sformatf("v%0d_done_pulses", v), nd, 1);
            check($sformatf("v%0d_er_cycles", v), ne, 0);
            check($sformatf("v%0d_underruns", v), nu, 0);
            check($sformatf("v%0d_queue_left", v), q.size(), 0);
            check($sformatf("v%0d_busy_end", v), 32'(busy), 0);
        end

        n = 0;
        push_frame(64, 8'h40);
        push_frame(64, 8'h80);
        repeat (200) step();
        analyze();
        check("b2b_runs", nr, 2);
        if (nr >= 2) begin
            check("b2b_len0", rl[0], 76);
            check("b2b_len1", rl[1], 76);
            check("b2b_gap", rs[1] - rs[0] - rl[0], 12);
            check_frame("b2b_f0", rs[0], rl[0], 64, 8'h40);
            check_frame("b2b_f1", rs[1], rl[1], 64, 8'h80);
        end
        check("b2b_done_pulses", nd, 2);

        n = 0; pops = 0; mark_pops = 100; mark_step = -1;
        push_frame(100, 8'h01);
        push_frame(10, 8'hC0);
        for (int k = 0; k < 100 && pops < 20; k++) step();
        check("ur_reach20", pops, 20);
        force_empty = 1'b1;
        repeat (3) step();
        force_empty = 1'b0;
        for (int k = 0; k < 300 && mark_step < 0; k++) step();
        repeat (100) step();
        analyze();
        check("ur_drain_complete", 32'(mark_step >= 0), 1);
        check("ur_runs", nr, 2);
        if (nr >= 2) begin
            check("ur_len0", rl[0], 29);
            check("ur_er_at_end", 32'(lg_er[rs[0]+28]), 1);
            check("ur_pulse_at_end", 32'(lg_ur[rs[0]+28]), 1);
            bad = 0;
            for (int i = 0; i < 20; i++) if (lg_d[rs[0]+8+i] !== 8'(8'h01 + i)) bad++;
            check("ur_payload_bad", bad, 0);
            check("ur_next_preamble", rs[1] - mark_step, 13);
            check("ur_len1", rl[1], EXP10);
            check_frame("ur_f1", rs[1], rl[1], 10, 8'hC0);
        end
        check("ur_er_cycles", ne, 1);
        check("ur_underruns", nu, 1);
        check("ur_done_pulses", nd, 1);
        check("ur_queue_left", q.size(), 0);

        n = 0; pops = 0; mark_pops = -1;
        push_frame(100, 8'h22);
        for (int k = 0; k < 100 && pops < 30; k++) step();
        check("rs_reach30", pops, 30);
        check("rs_mid_tx_en", 32'(tx_en), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rs_tx_en", 32'(tx_en), 0);
        check("rs_tx_er", 32'(tx_er), 0);
        check("rs_busy", 32'(busy), 0);
        check("rs_rd_en", 32'(rd_en), 0);
        q.delete();
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        push_frame(60, 8'h77);
        repeat (92) step();
        analyze();
        check("rs_runs", nr, 1);
        if (nr >= 1) begin
            check("rs_start", rs[0], 0);
            check("rs_tx_en_cycles", rl[0], 72);
            check_frame("rs_f", rs[0], rl[0], 60, 8'h77);
        end
        check("rs_done_pulses", nd, 1);

        check("pop_while_empty", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
